// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the Hack data-RAM arbiter and its environment
// (CPU data port, DMA requester, single-port RAM macro).
interface hack_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rd;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  stall_cnt;

  // Arbiter side: serves the CPU and DMA requesters and drives the RAM.
  modport slave (
    input  cpu_addr, cpu_rd, cpu_we, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_cnt
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_we, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Arbiter for the Hack single-port data RAM: CPU vs. one DMA master, with
// one-cycle read stall, atomic CPU read-modify-write and a stall counter.
module hack_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  hack_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, CPU_RD} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;     // 0 = CPU, 1 = DMA
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              cpu_req, cpu_win, dma_win;
  logic              mem_en, mem_we, cpu_stall, dma_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, cpu_rdata;

  assign cpu_req = bus.cpu_rd | bus.cpu_we;
  assign cpu_win = cpu_req & (~bus.dma_req | last_gnt_q);
  assign dma_win = bus.dma_req & (~cpu_req | ~last_gnt_q);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    dma_rvalid_d = 1'b0;
    hold_d       = hold_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = bus.cpu_addr;
    mem_wdata    = bus.cpu_wdata;
    cpu_stall    = 1'b0;
    dma_gnt      = 1'b0;
    cpu_rdata    = hold_q;

    if (!reset) begin
      // Outputs are forced safe while reset is held, independent of the clock.
      cpu_stall = 1'b1;
      cpu_rdata = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req && bus.dma_req) last_gnt_d = dma_win;
          if (cpu_req && !cpu_win)    cpu_stall  = 1'b1;
          if (cpu_win) begin
            mem_en = 1'b1;
            if (bus.cpu_rd) begin
              cpu_stall = 1'b1;
              state_d   = CPU_RD;
            end else begin
              mem_we = 1'b1;
            end
          end else if (dma_win) begin
            dma_gnt      = 1'b1;
            mem_en       = 1'b1;
            mem_we       = bus.dma_we;
            mem_addr     = bus.dma_addr;
            mem_wdata    = bus.dma_wdata;
            dma_rvalid_d = ~bus.dma_we;
          end
        end
        CPU_RD: begin
          // Read data returns now; the write half of an RMW lands in the same
          // cycle so no DMA access can slip in between.
          cpu_rdata = bus.mem_rdata;
          hold_d    = bus.mem_rdata;
          if (bus.cpu_we) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    stall_cnt_d = (cpu_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                     : stall_cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b0;
      dma_rvalid_q <= 1'b0;
      hold_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      hold_q       <= hold_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter: RAM model, read-data scoreboards and a
// second instance with a 3-bit stall counter for the saturation case.
module tb_hack_mem_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hack_mem_arbiter_if              b1 ();
  hack_mem_arbiter_if #(.CNT_W(3)) b2 ();

  hack_mem_arbiter u1 (.clk(clk), .reset(reset), .bus(b1));
  hack_mem_arbiter #(.CNT_W(3)) u2 (.clk(clk), .reset(reset), .bus(b2));

  logic [15:0] ram [0:32767];
  logic [15:0] rd_q;
  logic        bd_we;
  logic [14:0] bd_addr;
  logic [15:0] bd_data;
  logic        rmw_mode;
  logic [15:0] tb_wdata;
  logic [15:0] cpu_exp_q [$];
  logic [15:0] dma_exp_q [$];

  // RMW instructions compute outM from inM combinationally, like the real CPU.
  assign b1.cpu_wdata = rmw_mode ? b1.cpu_rdata + 16'd1 : tb_wdata;
  assign b1.mem_rdata = rd_q;
  assign b2.mem_rdata = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (b1.mem_en) begin
      if (b1.mem_we) ram[b1.mem_addr] <= b1.mem_wdata;
      else           rd_q <= ram[b1.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DMA read-data scoreboard: every dma_rvalid consumes one expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && b1.dma_rvalid === 1'b1) begin
      if (dma_exp_q.size() == 0) check("dma_rvalid_unexpected", {31'd0, b1.dma_rvalid}, 32'd0);
      else                       check("dma_rdata", {16'd0, b1.dma_rdata}, {16'd0, dma_exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.cpu_addr = '0; b1.cpu_rd = 1'b0; b1.cpu_we = 1'b0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = '0; b1.dma_wdata = '0;
    b2.cpu_addr = '0; b2.cpu_rd = 1'b0; b2.cpu_we = 1'b0; b2.cpu_wdata = '0;
    b2.dma_req = 1'b0; b2.dma_we = 1'b0; b2.dma_addr = '0; b2.dma_wdata = '0;
    rmw_mode = 1'b0;
    tb_wdata = '0;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    // Requests present during reset must not reach the RAM.
    b1.cpu_we = 1'b1; b1.cpu_addr = 15'd3; b1.dma_req = 1'b1;
    poke(15'd5, 16'h0007);
    poke(15'd10, 16'hBEEF);
    poke(15'd30, 16'h1234);
    @(negedge clk);
    check("rst_mem_en",    {31'd0, b1.mem_en},     32'd0);
    check("rst_mem_we",    {31'd0, b1.mem_we},     32'd0);
    check("rst_dma_gnt",   {31'd0, b1.dma_gnt},    32'd0);
    check("rst_cpu_stall", {31'd0, b1.cpu_stall},  32'd1);
    check("rst_cpu_rdata", {16'd0, b1.cpu_rdata},  32'd0);
    check("rst_stall_cnt", {16'd0, b1.stall_cnt},  32'd0);
    check("rst_rvalid",    {31'd0, b1.dma_rvalid}, 32'd0);
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();

    // CPU write-only, uncontended: zero stall.
    b1.cpu_we = 1'b1; b1.cpu_addr = 15'd3; tb_wdata = 16'h00FF;
    @(negedge clk);
    check("wr_mem_en",    {31'd0, b1.mem_en},    32'd1);
    check("wr_mem_we",    {31'd0, b1.mem_we},    32'd1);
    check("wr_mem_addr",  {17'd0, b1.mem_addr},  32'd3);
    check("wr_mem_wdata", {16'd0, b1.mem_wdata}, 32'h00FF);
    check("wr_stall",     {31'd0, b1.cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("wr_ram3",      {16'd0, ram[3]},       32'h00FF);
    check("wr_stall_cnt", {16'd0, b1.stall_cnt}, 32'd0);
    tick();

    // Atomic read-modify-write M=M+1 on address 5.
    rmw_mode = 1'b1; b1.cpu_rd = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 15'd5;
    cpu_exp_q.push_back(16'h0007);
    @(negedge clk);
    check("rmw0_mem_en", {31'd0, b1.mem_en},    32'd1);
    check("rmw0_mem_we", {31'd0, b1.mem_we},    32'd0);
    check("rmw0_addr",   {17'd0, b1.mem_addr},  32'd5);
    check("rmw0_stall",  {31'd0, b1.cpu_stall}, 32'd1);
    tick();
    @(negedge clk);
    check("rmw1_rdata",  {16'd0, b1.cpu_rdata}, {16'd0, cpu_exp_q.pop_front()});
    check("rmw1_mem_we", {31'd0, b1.mem_we},    32'd1);
    check("rmw1_wdata",  {16'd0, b1.mem_wdata}, 32'h0008);
    check("rmw1_stall",  {31'd0, b1.cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rmw_ram5",      {16'd0, ram[5]},       32'h0008);
    check("rmw_stall_cnt", {16'd0, b1.stall_cnt}, 32'd1);
    check("rmw_hold",      {16'd0, b1.cpu_rdata}, 32'h0007);
    tick();

    // Fresh reset, then CPU write vs. DMA write contending for 4 cycles.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    b1.cpu_we = 1'b1; b1.cpu_addr = 15'd20; tb_wdata = 16'h1111;
    b1.dma_req = 1'b1; b1.dma_we = 1'b1; b1.dma_addr = 15'd21; b1.dma_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      logic exp_dma;
      exp_dma = (i % 2 == 0);
      @(negedge clk);
      check($sformatf("alt%0d_gnt", i),   {31'd0, b1.dma_gnt},   {31'd0, exp_dma});
      check($sformatf("alt%0d_stall", i), {31'd0, b1.cpu_stall}, {31'd0, exp_dma});
      check($sformatf("alt%0d_addr", i),  {17'd0, b1.mem_addr},  exp_dma ? 32'd21 : 32'd20);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("alt_ram20",     {16'd0, ram[20]},      32'h1111);
    check("alt_ram21",     {16'd0, ram[21]},      32'h2222);
    check("alt_stall_cnt", {16'd0, b1.stall_cnt}, 32'd2);
    tick();

    // DMA read raised while the CPU read is in CPU_RD.
    b1.cpu_rd = 1'b1; b1.cpu_addr = 15'd5;
    cpu_exp_q.push_back(16'h0008);
    @(negedge clk);
    check("dr0_stall", {31'd0, b1.cpu_stall}, 32'd1);
    tick();
    b1.dma_req = 1'b1; b1.dma_we = 1'b0; b1.dma_addr = 15'd10;
    @(negedge clk);
    check("dr1_gnt",    {31'd0, b1.dma_gnt},   32'd0);
    check("dr1_stall",  {31'd0, b1.cpu_stall}, 32'd0);
    check("dr1_mem_en", {31'd0, b1.mem_en},    32'd0);
    check("dr1_rdata",  {16'd0, b1.cpu_rdata}, {16'd0, cpu_exp_q.pop_front()});
    tick();
    b1.cpu_rd = 1'b0;
    dma_exp_q.push_back(16'hBEEF);
    @(negedge clk);
    check("dr2_gnt",    {31'd0, b1.dma_gnt},  32'd1);
    check("dr2_mem_we", {31'd0, b1.mem_we},   32'd0);
    check("dr2_addr",   {17'd0, b1.mem_addr}, 32'd10);
    tick();
    b1.dma_req = 1'b0;
    @(negedge clk);
    check("dr3_rvalid", {31'd0, b1.dma_rvalid}, 32'd1);
    tick();
    @(negedge clk);
    check("dr4_rvalid", {31'd0, b1.dma_rvalid}, 32'd0);
    tick();

    // Reset in the middle of CPU_RD with a pending write.
    b1.cpu_rd = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 15'd30; tb_wdata = 16'hDEAD;
    @(negedge clk);
    check("rr0_stall", {31'd0, b1.cpu_stall}, 32'd1);
    tick();
    #1;
    check("rr1_rdata",  {16'd0, b1.cpu_rdata}, 32'h1234);
    check("rr1_mem_we", {31'd0, b1.mem_we},    32'd1);
    reset = 1'b0;
    #1;
    check("rr_mem_en",    {31'd0, b1.mem_en},    32'd0);
    check("rr_mem_we",    {31'd0, b1.mem_we},    32'd0);
    check("rr_stall",     {31'd0, b1.cpu_stall}, 32'd1);
    check("rr_cpu_rdata", {16'd0, b1.cpu_rdata}, 32'd0);
    check("rr_stall_cnt", {16'd0, b1.stall_cnt}, 32'd0);
    tick();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("rr_ram30", {16'd0, ram[30]}, 32'h1234);
    tick();

    // Reset just after a DMA read grant: no dma_rvalid may appear.
    b1.dma_req = 1'b1; b1.dma_we = 1'b0; b1.dma_addr = 15'd10;
    @(negedge clk);
    check("rd_gnt", {31'd0, b1.dma_gnt}, 32'd1);
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rd_rvalid_reset", {31'd0, b1.dma_rvalid}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 3-bit stall counter under continuous CPU read vs. DMA read contention.
    b2.cpu_rd = 1'b1; b2.cpu_addr = 15'd1;
    b2.dma_req = 1'b1; b2.dma_we = 1'b0; b2.dma_addr = 15'd2;
    @(negedge clk);
    check("sat_cnt_start", {29'd0, b2.stall_cnt}, 32'd0);
    check("sat_first_gnt", {31'd0, b2.dma_gnt},   32'd1);
    repeat (3) tick();
    check("sat_cnt_3cyc", {29'd0, b2.stall_cnt}, 32'd2);
    repeat (17) tick();
    check("sat_cnt_hold", {29'd0, b2.stall_cnt}, 32'd7);
    idle_inputs();
    tick();

    check("cpu_sb_empty", cpu_exp_q.size(), 32'd0);
    check("dma_sb_empty", dma_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
